// File: rtl/lsu_pkg.sv
// lsu_pkg: shared codes, state encoding and size helper for the load/store unit.
package lsu_pkg;

    // Data-memory access codes (shared encoding with the data memory).
    localparam logic [2:0] LB   = 3'b000;
    localparam logic [2:0] LH   = 3'b001;
    localparam logic [2:0] LW   = 3'b010;
    localparam logic [2:0] LB_U = 3'b100;
    localparam logic [2:0] LH_U = 3'b101;
    localparam logic [2:0] SB   = 3'b000;
    localparam logic [2:0] SH   = 3'b001;
    localparam logic [2:0] SW   = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Access size in bytes for a ctrl code; 0 marks an undefined code.
    function automatic logic [2:0] lsu_size(input logic [2:0] ctrl);
        case (ctrl)
            3'b000, 3'b100: return 3'd1;
            3'b001, 3'b101: return 3'd2;
            3'b010:         return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: widens a raw little-endian load result to 32 bits per ctrl.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [2:0]  i_ctrl,
    output logic [31:0] o_data
);

    // Sign- or zero-extend the low byte/halfword; words pass straight through.
    always_comb begin
        o_data = 32'd0;
        case (i_ctrl)
            LB:      o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            LH:      o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            LW:      o_data = i_raw;
            LB_U:    o_data = {24'd0, i_raw[7:0]};
            LH_U:    o_data = {16'd0, i_raw[15:0]};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the data-memory port.
// Aligned accesses use one memory cycle; misaligned halfword/word accesses are
// walked byte by byte (LB_U/SB) and reassembled. Bus outputs and the response
// are decoded from the state register, so an async reset removes DMWr at once.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [2:0]  ReqCtrl,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        Fault,
    output logic [31:0] Address,
    output logic [31:0] DataWr,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    input  logic [31:0] DataRd
);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic        r_write;
    logic [2:0]  r_ctrl;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_result;
    logic        r_fault;
    logic [1:0]  r_idx;
    logic [1:0]  r_last;

    logic [2:0]  w_size;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_fault;
    logic [31:0] w_ext;

    lsu_load_extend u_ext (
        .i_raw  (r_result),
        .i_ctrl (r_ctrl),
        .o_data (w_ext)
    );

    // Classify the request on the core port (only acted on in IDLE).
    always_comb begin
        w_size       = lsu_size(ReqCtrl);
        w_illegal    = (w_size == 3'd0) || (ReqWrite && ReqCtrl[2]);
        w_misaligned = ((w_size == 3'd2) && ReqAddr[0]) ||
                       ((w_size == 3'd4) && (ReqAddr[1:0] != 2'b00));
        w_fault      = w_illegal || (w_misaligned && !ALLOW_MISALIGNED);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus all core/memory outputs, decoded from the current state.
    always_comb begin
        w_next    = r_state;
        ReqReady  = 1'b0;
        RespValid = 1'b0;
        RespData  = 32'd0;
        Fault     = 1'b0;
        Address   = 32'd0;
        DataWr    = 32'd0;
        DMWr      = 1'b0;
        DMCtrl    = 3'b000;
        case (r_state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    if (w_fault)           w_next = RESP;
                    else if (w_misaligned) w_next = SPLIT;
                    else                   w_next = ACCESS;
                end
            end
            ACCESS: begin
                Address = r_addr;
                DMCtrl  = r_ctrl;
                DataWr  = r_wdata;
                DMWr    = r_write;
                w_next  = RESP;
            end
            SPLIT: begin
                // Byte walk: address wraps naturally at 32 bits.
                Address = r_addr + {30'd0, r_idx};
                DMCtrl  = r_write ? SB : LB_U;
                DataWr  = {24'd0, r_wdata[{r_idx, 3'b000} +: 8]};
                DMWr    = r_write;
                if (r_idx == r_last) w_next = RESP;
            end
            RESP: begin
                RespValid = 1'b1;
                Fault     = r_fault;
                RespData  = (r_fault || r_write) ? 32'd0 : w_ext;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, load-result assembly and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_ctrl   <= 3'b000;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_result <= 32'd0;
            r_fault  <= 1'b0;
            r_idx    <= 2'd0;
            r_last   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        r_write  <= ReqWrite;
                        r_ctrl   <= ReqCtrl;
                        r_addr   <= ReqAddr;
                        r_wdata  <= ReqWData;
                        r_fault  <= w_fault;
                        r_result <= 32'd0;
                        r_idx    <= 2'd0;
                        r_last   <= (w_size == 3'd4) ? 2'd3 : 2'd1;
                    end
                end
                ACCESS: begin
                    if (!r_write) r_result <= DataRd;
                end
                SPLIT: begin
                    if (!r_write) r_result[{r_idx, 3'b000} +: 8] <= DataRd[7:0];
                    r_idx <= r_idx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
